// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit: CSR addresses,
// operation encoding, status/interrupt bit positions and WARL masks.
package csr_trap_unit_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS      = 12'h300;
  localparam logic [11:0] CSR_MISA         = 12'h301;
  localparam logic [11:0] CSR_MIE          = 12'h304;
  localparam logic [11:0] CSR_MTVEC        = 12'h305;
  localparam logic [11:0] CSR_MHPMEVENT3   = 12'h323;
  localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [11:0] CSR_MEPC         = 12'h341;
  localparam logic [11:0] CSR_MCAUSE       = 12'h342;
  localparam logic [11:0] CSR_MTVAL        = 12'h343;
  localparam logic [11:0] CSR_MIP          = 12'h344;
  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3 = 12'hB03;
  localparam logic [11:0] CSR_MHARTID      = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam int MIP_MSI = 3;
  localparam int MIP_MTI = 7;
  localparam int MIP_MEI = 11;

  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

  localparam logic [11:0] MIE_WARL_MASK    = 12'h888;
  localparam logic [4:0]  MCAUSE_CODE_MASK = 5'h1f;

  function automatic logic [1:0] misa_mxl(input int xlen);
    return (xlen == 64) ? 2'd2 : (xlen == 128) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// CSR access port between the pipeline (execute read, writeback commit)
// and the CSR unit.
interface csr_trap_unit_if #(parameter int XLEN = 64);
  import csr_trap_unit_pkg::*;

  logic [11:0]     ra;
  logic [XLEN-1:0] rd;
  logic            ra_illegal;
  logic            we;
  logic [11:0]     wa;
  csr_op_t         wop;
  logic [XLEN-1:0] wsrc;
  logic            wr_illegal;

  modport master (output ra, we, wa, wop, wsrc, input rd, ra_illegal, wr_illegal);
  modport slave  (input ra, we, wa, wop, wsrc, output rd, ra_illegal, wr_illegal);
endinterface

// File: rtl/csr_trap_unit_counter.sv
// Free-running wrap-around counter whose CSR write takes precedence
// over the increment in the same cycle.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)   count <= '0;
    else if (we) count <= wd;
    else         count <= count + {{(XLEN-1){1'b0}}, inc};
  end
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry, mret, interrupt request and
// fetch redirect generation.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int NUM_HPM     = 4,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  csr_trap_unit_if.slave     bus,
  input  logic               instret,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               trap_valid,
  input  logic               trap_int,
  input  logic [4:0]         trap_code,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_tval,
  input  logic               mret_valid,
  input  logic               irq_sw,
  input  logic               irq_timer,
  input  logic               irq_ext,
  output logic               irq_req,
  output logic [4:0]         irq_code,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc
);
  typedef logic [XLEN-1:0] word_t;
  localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;

  localparam word_t MISA_VAL    = (word_t'(misa_mxl(XLEN)) << (XLEN-2)) | (word_t'(1) << 8);
  localparam word_t MIE_WARL    = word_t'(MIE_WARL_MASK);
  localparam word_t MTVEC_WARL  = ~word_t'(VECTORED_EN ? 2 : 3);
  localparam word_t MEPC_WARL   = ~word_t'(3);
  localparam word_t MCAUSE_WARL = (word_t'(1) << (XLEN-1)) | word_t'(MCAUSE_CODE_MASK);

  logic  st_mie, st_mpie;
  logic  mip_sw, mip_ti, mip_ex;
  word_t mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  word_t hpm_evt_q [HPM_N];
  word_t hpm_cnt   [HPM_N];
  word_t cyc_cnt, ret_cnt;
  word_t mstatus_val, mip_val, pend;
  word_t w_old, w_new;
  logic  w_en, wr_ill;

  assign mstatus_val = (word_t'(2'b11) << MSTATUS_MPP_LO) | (word_t'(st_mpie) << MSTATUS_MPIE)
                     | (word_t'(st_mie) << MSTATUS_MIE);
  assign mip_val = (word_t'(mip_ex) << MIP_MEI) | (word_t'(mip_ti) << MIP_MTI)
                 | (word_t'(mip_sw) << MIP_MSI);

  function automatic logic csr_exists(input logic [11:0] a);
    logic hit;
    case (a)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    for (int i = 0; i < NUM_HPM; i++)
      if (a == 12'(CSR_MHPMCOUNTER3 + i) || a == 12'(CSR_MHPMEVENT3 + i)) hit = 1'b1;
    return hit;
  endfunction

  function automatic word_t csr_value(input logic [11:0] a);
    word_t v;
    case (a)
      CSR_MSTATUS:  v = mstatus_val;
      CSR_MISA:     v = MISA_VAL;
      CSR_MIE:      v = mie_q;
      CSR_MTVEC:    v = mtvec_q;
      CSR_MSCRATCH: v = mscratch_q;
      CSR_MEPC:     v = mepc_q;
      CSR_MCAUSE:   v = mcause_q;
      CSR_MTVAL:    v = mtval_q;
      CSR_MIP:      v = mip_val;
      CSR_MCYCLE:   v = cyc_cnt;
      CSR_MINSTRET: v = ret_cnt;
      default:      v = '0;
    endcase
    for (int i = 0; i < NUM_HPM; i++) begin
      if (a == 12'(CSR_MHPMCOUNTER3 + i)) v = hpm_cnt[i];
      if (a == 12'(CSR_MHPMEVENT3 + i))   v = hpm_evt_q[i];
    end
    return v;
  endfunction

  assign bus.rd         = csr_value(bus.ra);
  assign bus.ra_illegal = !csr_exists(bus.ra);
  assign wr_ill         = bus.we && ((bus.wa[11:10] == 2'b11) || !csr_exists(bus.wa));
  assign bus.wr_illegal = wr_ill;

  always_comb begin
    w_old = csr_value(bus.wa);
    case (bus.wop)
      CSR_OP_SET:   w_new = w_old | bus.wsrc;
      CSR_OP_CLEAR: w_new = w_old & ~bus.wsrc;
      default:      w_new = bus.wsrc;
    endcase
  end

  // Traps and mret pre-empt the CSR commit; set/clear with a zero mask is a legal no-op.
  assign w_en = bus.we && !trap_valid && !mret_valid && !wr_ill
             && (bus.wop == CSR_OP_WRITE
                 || ((bus.wop == CSR_OP_SET || bus.wop == CSR_OP_CLEAR) && bus.wsrc != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mip_sw     <= 1'b0;
      mip_ti     <= 1'b0;
      mip_ex     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      for (int i = 0; i < HPM_N; i++) hpm_evt_q[i] <= '0;
    end else begin
      mip_sw <= irq_sw;
      mip_ti <= irq_timer;
      mip_ex <= irq_ext;
      if (trap_valid) begin
        mepc_q   <= trap_pc & MEPC_WARL;
        mcause_q <= (word_t'(trap_int) << (XLEN-1)) | word_t'(trap_code);
        mtval_q  <= trap_tval;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret_valid) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (w_en) begin
        case (bus.wa)
          CSR_MSTATUS: begin
            st_mie  <= w_new[MSTATUS_MIE];
            st_mpie <= w_new[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= w_new & MIE_WARL;
          CSR_MTVEC:    mtvec_q    <= w_new & MTVEC_WARL;
          CSR_MSCRATCH: mscratch_q <= w_new;
          CSR_MEPC:     mepc_q     <= w_new & MEPC_WARL;
          CSR_MCAUSE:   mcause_q   <= w_new & MCAUSE_WARL;
          CSR_MTVAL:    mtval_q    <= w_new;
          default: ;
        endcase
        for (int i = 0; i < NUM_HPM; i++)
          if (bus.wa == 12'(CSR_MHPMEVENT3 + i)) hpm_evt_q[i] <= w_new;
      end
    end
  end

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk(clk), .reset(reset), .inc(1'b1),
    .we(w_en && bus.wa == CSR_MCYCLE), .wd(w_new), .count(cyc_cnt)
  );
  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk(clk), .reset(reset), .inc(instret),
    .we(w_en && bus.wa == CSR_MINSTRET), .wd(w_new), .count(ret_cnt)
  );

  // A counter whose event selector is zero is frozen.
  for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
    csr_counter #(.XLEN(XLEN)) u_hpm (
      .clk(clk), .reset(reset), .inc(hpm_event[g] && hpm_evt_q[g] != '0),
      .we(w_en && bus.wa == 12'(CSR_MHPMCOUNTER3 + g)), .wd(w_new), .count(hpm_cnt[g])
    );
  end
  if (NUM_HPM == 0) begin : g_no_hpm
    assign hpm_cnt[0] = '0;
  end

  assign pend    = mip_val & mie_q;
  assign irq_req = st_mie && (pend != '0);

  always_comb begin
    irq_code = '0;
    if (irq_req) begin
      if (pend[MIP_MEI])      irq_code = IRQ_CODE_MEI;
      else if (pend[MIP_MSI]) irq_code = IRQ_CODE_MSI;
      else                    irq_code = IRQ_CODE_MTI;
    end
  end

  assign redirect_valid = !reset && (trap_valid || mret_valid);

  always_comb begin
    redirect_pc = '0;
    if (!reset && trap_valid) begin
      redirect_pc = {mtvec_q[XLEN-1:2], 2'b00};
      if (trap_int && mtvec_q[0]) redirect_pc = redirect_pc + (word_t'(trap_code) << 2);
    end else if (!reset && mret_valid) begin
      redirect_pc = mepc_q;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios followed by random traffic,
// all outputs compared every cycle against an address-map reference model.
module tb_csr_trap_unit;
  import csr_trap_unit_pkg::*;

  localparam int XLEN    = 64;
  localparam int NUM_HPM = 4;
  typedef logic [63:0] u64;

  logic clk = 1'b0;
  logic reset;
  logic instret;
  logic [NUM_HPM-1:0] hpm_event;
  logic trap_valid, trap_int, mret_valid;
  logic [4:0] trap_code;
  u64   trap_pc, trap_tval;
  logic irq_sw, irq_timer, irq_ext;
  logic irq_req, redirect_valid;
  logic [4:0] irq_code;
  u64   redirect_pc;

  csr_trap_unit_if #(.XLEN(XLEN)) bus ();

  csr_trap_unit #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .instret(instret), .hpm_event(hpm_event),
    .trap_valid(trap_valid), .trap_int(trap_int), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_req(irq_req), .irq_code(irq_code),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input u64 obs, input u64 exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: address -> architectural value, with per-address writable
  // mask and hardwired bits.
  u64 st [int];
  u64 wmask [int];
  u64 fixed [int];
  bit model_ok = 1'b0;

  function automatic void def_csr(input int a, input u64 m, input u64 f);
    st[a] = f;
    wmask[a] = m;
    fixed[a] = f;
  endfunction

  function automatic void model_reset();
    st.delete();
    def_csr('h300, 64'h88, 64'h1800);
    def_csr('h301, 64'h0, 64'h8000_0000_0000_0100);
    def_csr('h304, 64'h888, 64'h0);
    def_csr('h305, ~64'h2, 64'h0);
    def_csr('h340, ~64'h0, 64'h0);
    def_csr('h341, ~64'h3, 64'h0);
    def_csr('h342, 64'h8000_0000_0000_001F, 64'h0);
    def_csr('h343, ~64'h0, 64'h0);
    def_csr('h344, 64'h0, 64'h0);
    def_csr('hB00, ~64'h0, 64'h0);
    def_csr('hB02, ~64'h0, 64'h0);
    for (int i = 0; i < NUM_HPM; i++) begin
      def_csr('hB03 + i, ~64'h0, 64'h0);
      def_csr('h323 + i, ~64'h0, 64'h0);
    end
    def_csr('hF14, 64'h0, 64'h0);
  endfunction

  function automatic u64 m_rd(input int a);
    return st.exists(a) ? st[a] : 64'h0;
  endfunction

  task automatic compare_outputs();
    u64 pend, tv, exp_pc;
    int prio [3] = '{11, 3, 7};
    int exp_code;
    bit exp_req, ill;
    chk_eq("rd", bus.rd, m_rd(int'(bus.ra)));
    chk_eq("ra_illegal", u64'(bus.ra_illegal), u64'(!st.exists(int'(bus.ra))));
    ill = bus.we && (bus.wa[11:10] == 2'b11 || !st.exists(int'(bus.wa)));
    chk_eq("wr_illegal", u64'(bus.wr_illegal), u64'(ill));
    exp_pc = 64'h0;
    if (!reset && trap_valid) begin
      tv = m_rd('h305);
      exp_pc = tv & ~64'h3;
      if (trap_int && tv[0]) exp_pc = exp_pc + 4 * u64'(trap_code);
    end else if (!reset && mret_valid) begin
      exp_pc = m_rd('h341);
    end
    chk_eq("redirect_valid", u64'(redirect_valid), u64'(!reset && (trap_valid || mret_valid)));
    chk_eq("redirect_pc", redirect_pc, exp_pc);
    pend = m_rd('h344) & m_rd('h304);
    tv = m_rd('h300);
    exp_req = tv[3] && (pend != 0);
    exp_code = 0;
    if (exp_req)
      for (int k = 2; k >= 0; k--) if (pend[prio[k]]) exp_code = prio[k];
    chk_eq("irq_req", u64'(irq_req), u64'(exp_req));
    chk_eq("irq_code", u64'(irq_code), u64'(exp_code));
  endtask

  task automatic model_edge();
    u64 old, nv, ms;
    int wa;
    bit ill;
    if (reset) begin
      model_reset();
      model_ok = 1'b1;
      return;
    end
    wa  = int'(bus.wa);
    old = m_rd(wa);
    case (bus.wop)
      CSR_OP_SET:   nv = old | bus.wsrc;
      CSR_OP_CLEAR: nv = old & ~bus.wsrc;
      default:      nv = bus.wsrc;
    endcase
    ill = bus.wa[11:10] == 2'b11 || !st.exists(wa);
    st['hB00] = st['hB00] + 1;
    st['hB02] = st['hB02] + u64'(instret);
    for (int i = 0; i < NUM_HPM; i++)
      if (st['h323 + i] != 0) st['hB03 + i] = st['hB03 + i] + u64'(hpm_event[i]);
    ms = st['h300];
    if (trap_valid) begin
      st['h341] = trap_pc & ~64'h3;
      st['h342] = (u64'(trap_int) << 63) | u64'(trap_code);
      st['h343] = trap_tval;
      st['h300] = 64'h1800 | (u64'(ms[3]) << 7);
    end else if (mret_valid) begin
      st['h300] = 64'h1880 | (u64'(ms[7]) << 3);
    end else if (bus.we && !ill && (bus.wop == CSR_OP_WRITE ||
                 (bus.wop != CSR_OP_NONE && bus.wsrc != 0))) begin
      st[wa] = (nv & wmask[wa]) | fixed[wa];
    end
    st['h344] = (u64'(irq_ext) << 11) | (u64'(irq_timer) << 7) | (u64'(irq_sw) << 3);
  endtask

  task automatic step();
    #1;
    if (model_ok) compare_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ra = 12'h0; bus.we = 1'b0; bus.wa = 12'h0; bus.wop = CSR_OP_NONE; bus.wsrc = '0;
    instret = 1'b0; hpm_event = '0; trap_valid = 1'b0; trap_int = 1'b0; trap_code = '0;
    trap_pc = '0; trap_tval = '0; mret_valid = 1'b0;
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
  endtask

  task automatic csr_op(input logic [11:0] a, input csr_op_t op, input u64 d);
    bus.we = 1'b1; bus.wa = a; bus.wop = op; bus.wsrc = d;
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input u64 exp);
    bus.ra = a;
    #1;
    chk_eq(tag, bus.rd, exp);
  endtask

  int pool [20] = '{'h300, 'h301, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344, 'hB00,
                    'hB02, 'hB03, 'hB04, 'hB05, 'hB06, 'h323, 'h324, 'h325, 'h326, 'hF14};

  function automatic logic [11:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 12'($urandom);
    return 12'(pool[$urandom_range(0, 19)]);
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    peek("mstatus_reset", 12'h300, 64'h1800);
    bus.ra = 12'hB00;
    repeat (5) step();
    peek("mcycle_5", 12'hB00, 64'd5);
    bus.ra = 12'h7C0;
    #1;
    chk_eq("unimpl_rd", bus.rd, 64'h0);
    chk_eq("unimpl_ra_illegal", u64'(bus.ra_illegal), 64'h1);

    csr_op(12'h300, CSR_OP_SET, 64'h8);      step(); bus.we = 1'b0;
    peek("mstatus_set_mie", 12'h300, 64'h1808);
    csr_op(12'h300, CSR_OP_CLEAR, 64'hFFFF); step(); bus.we = 1'b0;
    peek("mstatus_clear", 12'h300, 64'h1800);
    csr_op(12'h305, CSR_OP_WRITE, 64'h1003); step(); bus.we = 1'b0;
    peek("mtvec_warl", 12'h305, 64'h1001);
    csr_op(12'h300, CSR_OP_SET, 64'h8);      step(); bus.we = 1'b0;

    trap_valid = 1'b1; trap_int = 1'b1; trap_code = 5'd7; trap_pc = 64'h8004; trap_tval = 64'h55;
    #1;
    chk_eq("trap_redirect_valid", u64'(redirect_valid), 64'h1);
    chk_eq("trap_redirect_pc", redirect_pc, 64'h101C);
    step();
    trap_valid = 1'b0; trap_int = 1'b0;
    peek("trap_mepc", 12'h341, 64'h8004);
    peek("trap_mcause", 12'h342, 64'h8000_0000_0000_0007);
    peek("trap_mstatus", 12'h300, 64'h1880);

    mret_valid = 1'b1;
    csr_op(12'h340, CSR_OP_WRITE, 64'hDEAD);
    #1;
    chk_eq("mret_redirect_pc", redirect_pc, 64'h8004);
    step();
    mret_valid = 1'b0; bus.we = 1'b0;
    peek("mret_mstatus", 12'h300, 64'h1888);
    peek("mret_drops_write", 12'h340, 64'h0);

    csr_op(12'h304, CSR_OP_WRITE, 64'h888); step(); bus.we = 1'b0;
    irq_timer = 1'b1; irq_ext = 1'b1;
    #1;
    chk_eq("irq_latency", u64'(irq_req), 64'h0);
    step();
    #1;
    chk_eq("irq_req", u64'(irq_req), 64'h1);
    chk_eq("irq_code_ext", u64'(irq_code), 64'd11);
    csr_op(12'h300, CSR_OP_CLEAR, 64'h8); step(); bus.we = 1'b0;
    #1;
    chk_eq("irq_masked", u64'(irq_req), 64'h0);

    csr_op(12'hB00, CSR_OP_WRITE, ~64'h0); step(); bus.we = 1'b0;
    peek("mcycle_written", 12'hB00, ~64'h0);
    step();
    peek("mcycle_wrap", 12'hB00, 64'h0);

    csr_op(12'hF14, CSR_OP_WRITE, 64'h5);
    #1;
    chk_eq("mhartid_wr_illegal", u64'(bus.wr_illegal), 64'h1);
    step();
    bus.we = 1'b0;
    peek("mhartid_unchanged", 12'hF14, 64'h0);

    for (int c = 0; c < 600; c++) begin
      bus.ra   = pick_addr();
      bus.we   = 1'($urandom_range(0, 1));
      bus.wa   = pick_addr();
      bus.wop  = csr_op_t'($urandom_range(0, 3));
      bus.wsrc = ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom};
      instret    = 1'($urandom_range(0, 1));
      hpm_event  = 4'($urandom);
      trap_valid = ($urandom_range(0, 15) == 0);
      trap_int   = 1'($urandom_range(0, 1));
      trap_code  = 5'($urandom);
      trap_pc    = {$urandom, $urandom};
      trap_tval  = {$urandom, $urandom};
      mret_valid = ($urandom_range(0, 11) == 0);
      irq_sw     = 1'($urandom_range(0, 1));
      irq_timer  = 1'($urandom_range(0, 1));
      irq_ext    = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file, second generation. Parametrised in XLEN and hardware performance-counter count.
- Performs CSR read-modify-write ops (write/set/clear) internally and enforces WARL masks.
- Handles trap entry and mret, and raises interrupt requests.
- Sits beside the pipeline: reads in the execute stage, commits writes/traps/mret in the writeback stage, and drives the fetch redirect.

Parameters:
XLEN, 64, data width of every CSR and data port
NUM_HPM, 4, number of mhpmcounterN/mhpmeventN pairs (N = 3..3+NUM_HPM-1), range 0..29
VECTORED_EN, 1, 1 = mtvec.MODE=1 honoured for interrupts; 0 = MODE hardwired 0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ra  in  12  read address
rd  out  XLEN  read data (combinational)
ra_illegal  out  1  ra unimplemented
we  in  1  commit a CSR instruction this cycle
wa  in  12  write address
wop  in  2  csr_op_t: 01 write, 10 set, 11 clear, 00 none
wsrc  in  XLEN  rs1/uimm operand
wr_illegal  out  1  we to read-only (wa[11:10]==2'b11) or unimplemented address
instret  in  1  one instruction retired this cycle
hpm_event  in  NUM_HPM  per-counter increment strobes
trap_valid  in  1  take trap this cycle
trap_int  in  1  trap is an interrupt
trap_code  in  5  cause code
trap_pc  in  XLEN  faulting/interrupted pc
trap_tval  in  XLEN  mtval value
mret_valid  in  1  commit mret
irq_sw, irq_timer, irq_ext  in  1 each  raw interrupt lines
irq_req  out  1  interrupt pending and enabled
irq_code  out  5  code of the highest-priority pending interrupt
redirect_valid  out  1  fetch redirect (combinational)
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: all CSRs 0 except mstatus.MPP=2'b11. mip sampled register cleared. All outputs 0.
- Implemented CSRs:
  - mstatus: only MIE(3), MPIE(7), MPP(12:11, hardwired 11) writable; all other bits read 0.
  - misa: constant (RV64I/RV32I MXL per XLEN, I bit); writes ignored.
  - mie: bits 3/7/11 writable.
  - mip: read-only view of the sampled lines.
  - mtvec: bit 1 forced 0; bit 0 forced 0 when VECTORED_EN=0.
  - mscratch: fully writable.
  - mepc: bits[1:0] forced 0.
  - mcause: bit XLEN-1 and [4:0] kept.
  - mtval: fully writable.
  - mcycle, minstret, mhpmcounterN, mhpmeventN: fully writable.
  - mhartid: read-only 0.
- Read path: rd = CSR value. Unknown ra gives rd=0, ra_illegal=1. No read bypass of a same-cycle write.
- Write op: new = wsrc (write), old|wsrc (set), old&~wsrc (clear), then WARL-masked.
  - Set/clear with wsrc==0 performs no write but is legal.
  - wr_illegal is combinational on we; a flagged write is dropped.
- Priority per cycle: reset > trap_valid > mret_valid > we. Lower-priority events in the same cycle are dropped.
- Trap entry (next edge):
  - mepc=trap_pc&~3; mcause={trap_int,0…,trap_code}; mtval=trap_tval.
  - MPIE=MIE, MIE=0.
  - Same cycle: redirect_valid=1, redirect_pc=mtvec base, +4*trap_code if trap_int && mtvec.MODE==1.
- mret (next edge): MIE=MPIE, MPIE=1. Same cycle: redirect_valid=1, redirect_pc=mepc.
- Interrupts:
  - mip bits 3/7/11 are registered copies of irq_sw/timer/ext, one cycle latency.
  - irq_req = mstatus.MIE & |(mip&mie).
  - irq_code priority: 11 > 3 > 7. irq_code=0 when irq_req=0.
- Counters:
  - mcycle +1 every cycle; minstret +instret; mhpmcounterN +hpm_event[N-3] when mhpmeventN!=0.
  - All wrap modulo 2^XLEN.
  - A same-cycle CSR write to a counter wins over its increment.

Decomposition:
- csr_pkg: CSR address constants, csr_op_t, mstatus/mip bit positions, interrupt cause codes, WARL mask constants.
- Sub-module csr_counter (params XLEN; inputs inc, we, wd; output count), instantiated 2+NUM_HPM times.

Test Plan:
- Reset, then read mstatus -> rd=0x1800. mcycle reads 5 after 5 cycles. ra=0x7C0 -> rd=0, ra_illegal=1.
- we wop=set wa=mstatus wsrc=0x8 -> MIE=1. Then wop=clear wsrc=0xFFFF -> mstatus=0x1800. Write mtvec=0x1003 -> reads 0x1001.
- mtvec=0x1001, MIE=1, trap_valid trap_int=1 code=7 pc=0x8004 -> redirect_pc=0x101C. Then mepc=0x8004, mcause=0x8000…0007, MIE=0, MPIE=1.
- mret after that trap -> redirect_pc=0x8004, MIE=1, MPIE=1. Same-cycle we to mscratch is dropped.
- mie=0x888, MIE=1, irq_timer and irq_ext high -> irq_req=1 one cycle later, irq_code=11. Clear MIE -> irq_req=0.
- mcycle written 2^XLEN-1 -> reads 0 next cycle. we to mhartid -> wr_illegal=1, value unchanged.
